// File: rtl/pid.sv
// RV32I instruction decode stage: decode, register-file read, load-use
// hazard detection, early JAL redirect, and the ID/EX pipeline register.
module pid #(
   parameter int XLEN = 32,
   parameter int RA_W = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   input  logic [XLEN-1:0] in_pc,
   input  logic [31:0]     in_inst,
   input  logic            stall_in,
   input  logic            flush_in,
   output logic [RA_W-1:0] rs1_addr,
   output logic [RA_W-1:0] rs2_addr,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [XLEN-1:0] rs2_data,
   output logic            stall_req,
   output logic            jump_ce,
   output logic [XLEN-1:0] jump_addr,
   output logic            ex_valid,
   output logic [XLEN-1:0] ex_pc,
   output logic [XLEN-1:0] ex_rs1_val,
   output logic [XLEN-1:0] ex_rs2_val,
   output logic [XLEN-1:0] ex_imm,
   output logic [RA_W-1:0] ex_rd,
   output logic            ex_wb_en,
   output logic [3:0]      ex_alu_op,
   output logic [1:0]      ex_a_sel,
   output logic            ex_b_imm,
   output logic            ex_mem_rd,
   output logic            ex_mem_wr,
   output logic [2:0]      ex_mem_size,
   output logic            ex_branch,
   output logic            ex_jump,
   output logic            ex_illegal
);

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   logic [6:0]      opc;
   logic [2:0]      f3;
   logic [RA_W-1:0] rd;
   logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

   logic [XLEN-1:0] d_imm;
   logic            d_wb, d_b_imm, d_mem_rd, d_mem_wr, d_branch, d_jump, d_illegal;
   logic            d_is_jal, use_rs1, use_rs2;
   logic [3:0]      d_alu_op;
   logic [1:0]      d_a_sel;
   logic [2:0]      d_mem_size;
   logic            hazard, accept;

   assign opc      = in_inst[6:0];
   assign f3       = in_inst[14:12];
   assign rd       = in_inst[11:7];
   assign rs1_addr = in_inst[19:15];
   assign rs2_addr = in_inst[24:20];

   assign imm_i = {{(XLEN-12){in_inst[31]}}, in_inst[31:20]};
   assign imm_s = {{(XLEN-12){in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
   assign imm_b = {{(XLEN-12){in_inst[31]}}, in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
   assign imm_u = {{(XLEN-31){in_inst[31]}}, in_inst[30:12], 12'b0};
   assign imm_j = {{(XLEN-20){in_inst[31]}}, in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};

   always_comb begin
      d_imm      = '0;
      d_wb       = 1'b0;
      d_alu_op   = 4'b0000;
      d_a_sel    = 2'd0;
      d_b_imm    = 1'b0;
      d_mem_rd   = 1'b0;
      d_mem_wr   = 1'b0;
      d_mem_size = 3'b000;
      d_branch   = 1'b0;
      d_jump     = 1'b0;
      d_illegal  = 1'b0;
      d_is_jal   = 1'b0;
      use_rs1    = 1'b0;
      use_rs2    = 1'b0;
      case (opc)
         OPC_LUI: begin
            d_imm = imm_u; d_wb = 1'b1; d_a_sel = 2'd2; d_b_imm = 1'b1;
         end
         OPC_AUIPC: begin
            d_imm = imm_u; d_wb = 1'b1; d_a_sel = 2'd1; d_b_imm = 1'b1;
         end
         OPC_JAL: begin
            d_imm = imm_j; d_wb = 1'b1; d_a_sel = 2'd1; d_b_imm = 1'b1;
            d_jump = 1'b1; d_is_jal = 1'b1;
         end
         OPC_JALR: begin
            d_imm = imm_i; d_wb = 1'b1; d_b_imm = 1'b1; d_jump = 1'b1; use_rs1 = 1'b1;
         end
         OPC_BRANCH: begin
            d_imm = imm_b; d_branch = 1'b1; d_alu_op = {1'b0, f3};
            use_rs1 = 1'b1; use_rs2 = 1'b1;
         end
         OPC_LOAD: begin
            d_imm = imm_i; d_wb = 1'b1; d_b_imm = 1'b1; d_mem_rd = 1'b1;
            d_mem_size = f3; use_rs1 = 1'b1;
         end
         OPC_STORE: begin
            d_imm = imm_s; d_b_imm = 1'b1; d_mem_wr = 1'b1; d_mem_size = f3;
            use_rs1 = 1'b1; use_rs2 = 1'b1;
         end
         OPC_OPIMM: begin
            // only the shift-right group carries the arithmetic flag in inst[30]
            d_imm = imm_i; d_wb = 1'b1; d_b_imm = 1'b1;
            d_alu_op = {(f3 == 3'b101) & in_inst[30], f3};
            use_rs1 = 1'b1;
         end
         OPC_OP: begin
            d_wb = 1'b1; d_alu_op = {in_inst[30], f3};
            use_rs1 = 1'b1; use_rs2 = 1'b1;
         end
         default: d_illegal = 1'b1;
      endcase
   end

   assign hazard = in_valid & ex_valid & ex_mem_rd & (ex_rd != '0) &
                   ((use_rs1 & (rs1_addr == ex_rd)) | (use_rs2 & (rs2_addr == ex_rd)));

   assign stall_req = ~flush_in & (stall_in | hazard);

   // jump_ce marks the ID slot as the wrong-path fall-through of an accepted JAL
   assign accept = in_valid & ~jump_ce;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         jump_ce     <= 1'b0;
         jump_addr   <= '0;
         ex_valid    <= 1'b0;
         ex_pc       <= '0;
         ex_rs1_val  <= '0;
         ex_rs2_val  <= '0;
         ex_imm      <= '0;
         ex_rd       <= '0;
         ex_wb_en    <= 1'b0;
         ex_alu_op   <= 4'b0000;
         ex_a_sel    <= 2'd0;
         ex_b_imm    <= 1'b0;
         ex_mem_rd   <= 1'b0;
         ex_mem_wr   <= 1'b0;
         ex_mem_size <= 3'b000;
         ex_branch   <= 1'b0;
         ex_jump     <= 1'b0;
         ex_illegal  <= 1'b0;
      end else if (flush_in) begin
         ex_valid <= 1'b0;
         jump_ce  <= 1'b0;
      end else if (stall_in) begin
         jump_ce <= 1'b0;
      end else if (hazard) begin
         ex_valid <= 1'b0;
         jump_ce  <= 1'b0;
      end else begin
         ex_valid    <= accept;
         ex_pc       <= in_pc;
         ex_rs1_val  <= rs1_data;
         ex_rs2_val  <= rs2_data;
         ex_imm      <= d_imm;
         ex_rd       <= rd;
         ex_wb_en    <= d_wb & (rd != '0);
         ex_alu_op   <= d_alu_op;
         ex_a_sel    <= d_a_sel;
         ex_b_imm    <= d_b_imm;
         ex_mem_rd   <= d_mem_rd;
         ex_mem_wr   <= d_mem_wr;
         ex_mem_size <= d_mem_size;
         ex_branch   <= d_branch;
         ex_jump     <= d_jump;
         ex_illegal  <= d_illegal;
         jump_ce     <= accept & d_is_jal;
         if (accept & d_is_jal)
            jump_addr <= in_pc + imm_j;
      end
   end

endmodule

// File: tb/tb_pid.sv
// Scoreboard bench for the decode stage: stimulus pushes expected ID/EX and
// combinational responses, a negedge monitor pops and compares them.
module tb_pid;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [31:0] in_pc, in_inst;
   logic        stall_in, flush_in;
   logic [4:0]  rs1_addr, rs2_addr;
   logic [31:0] rs1_data, rs2_data;
   logic        stall_req, jump_ce;
   logic [31:0] jump_addr;
   logic        ex_valid;
   logic [31:0] ex_pc, ex_rs1_val, ex_rs2_val, ex_imm;
   logic [4:0]  ex_rd;
   logic        ex_wb_en;
   logic [3:0]  ex_alu_op;
   logic [1:0]  ex_a_sel;
   logic        ex_b_imm, ex_mem_rd, ex_mem_wr;
   logic [2:0]  ex_mem_size;
   logic        ex_branch, ex_jump, ex_illegal;

   pid #(.XLEN(32), .RA_W(5)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst),
      .stall_in(stall_in), .flush_in(flush_in),
      .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
      .stall_req(stall_req), .jump_ce(jump_ce), .jump_addr(jump_addr),
      .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val),
      .ex_imm(ex_imm), .ex_rd(ex_rd), .ex_wb_en(ex_wb_en), .ex_alu_op(ex_alu_op),
      .ex_a_sel(ex_a_sel), .ex_b_imm(ex_b_imm), .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr),
      .ex_mem_size(ex_mem_size), .ex_branch(ex_branch), .ex_jump(ex_jump),
      .ex_illegal(ex_illegal)
   );

   always #5 clk = ~clk;

   typedef struct {
      int unsigned due;
      logic        v;
      logic [4:0]  rd;
      logic [31:0] imm, pc, r1, r2;
      logic        wb;
      logic [3:0]  alu;
      logic [1:0]  asel;
      logic        bimm, mrd, mwr;
      logic [2:0]  size;
      logic        br, jmp, ill, jce;
      logic [31:0] ja;
      logic        skip_rd, skip_ctl, skip_imm;
   } ex_t;

   typedef struct {
      int unsigned due;
      logic        stall;
      logic [4:0]  a1, a2;
   } comb_t;

   ex_t   eq[$];
   comb_t cq[$];
   ex_t   last_e;
   int unsigned cyc = 0;
   int total = 0;
   int bad = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic ex_t mk(input logic v, input logic [4:0] rd, input logic [31:0] imm,
                              input logic wb, input logic [3:0] alu, input logic [1:0] asel,
                              input logic bimm, input logic mrd, input logic mwr,
                              input logic [2:0] size, input logic br, input logic jmp,
                              input logic ill, input logic jce, input logic [31:0] ja);
      ex_t e;
      e.due = 0; e.v = v; e.rd = rd; e.imm = imm; e.pc = '0; e.r1 = '0; e.r2 = '0;
      e.wb = wb; e.alu = alu; e.asel = asel; e.bimm = bimm; e.mrd = mrd; e.mwr = mwr;
      e.size = size; e.br = br; e.jmp = jmp; e.ill = ill; e.jce = jce; e.ja = ja;
      e.skip_rd = 1'b0; e.skip_ctl = 1'b0; e.skip_imm = 1'b0;
      return e;
   endfunction

   function automatic ex_t bub(input logic [31:0] ja);
      return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ja);
   endfunction

   task automatic check_ex(input ex_t e);
      cmp("ex_valid", ex_valid, e.v);
      cmp("jump_ce", jump_ce, e.jce);
      cmp("jump_addr", jump_addr, e.ja);
      if (e.v) begin
         cmp("ex_pc", ex_pc, e.pc);
         cmp("ex_rs1_val", ex_rs1_val, e.r1);
         cmp("ex_rs2_val", ex_rs2_val, e.r2);
         cmp("ex_wb_en", ex_wb_en, e.wb);
         cmp("ex_mem_rd", ex_mem_rd, e.mrd);
         cmp("ex_mem_wr", ex_mem_wr, e.mwr);
         cmp("ex_branch", ex_branch, e.br);
         cmp("ex_jump", ex_jump, e.jmp);
         cmp("ex_illegal", ex_illegal, e.ill);
         if (!e.skip_rd)  cmp("ex_rd", ex_rd, e.rd);
         if (!e.skip_imm) cmp("ex_imm", ex_imm, e.imm);
         if (!e.skip_ctl) begin
            cmp("ex_alu_op", ex_alu_op, e.alu);
            cmp("ex_a_sel", ex_a_sel, e.asel);
            cmp("ex_b_imm", ex_b_imm, e.bimm);
         end
         if (e.mrd | e.mwr) cmp("ex_mem_size", ex_mem_size, e.size);
      end
   endtask

   task automatic check_zero(input string tag);
      cmp({tag, "_ex_valid"}, ex_valid, 0);
      cmp({tag, "_jump_ce"}, jump_ce, 0);
      cmp({tag, "_jump_addr"}, jump_addr, 0);
      cmp({tag, "_payload"}, ex_pc | ex_rs1_val | ex_rs2_val | ex_imm, 0);
      cmp({tag, "_ctl"}, {ex_rd, ex_wb_en, ex_alu_op, ex_a_sel, ex_b_imm, ex_mem_rd,
                         ex_mem_wr, ex_mem_size, ex_branch, ex_jump, ex_illegal}, 0);
   endtask

   // monitor: compare whatever the DUT presents this cycle against the queues
   always @(negedge clk) begin
      if (!rst) begin
         comb_t c;
         ex_t   e;
         while (cq.size() > 0 && cq[0].due == cyc) begin
            c = cq.pop_front();
            cmp("stall_req", stall_req, c.stall);
            cmp("rs1_addr", rs1_addr, c.a1);
            cmp("rs2_addr", rs2_addr, c.a2);
         end
         while (eq.size() > 0 && eq[0].due == cyc) begin
            e = eq.pop_front();
            check_ex(e);
         end
      end
   end

   task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                       input logic st, input logic fl, input logic exp_stall,
                       input ex_t e, input logic hold);
      comb_t c;
      @(posedge clk);
      #1;
      in_valid = v; in_pc = pc; in_inst = inst; stall_in = st; flush_in = fl;
      rs1_data = 32'h1000_0000 ^ pc;
      rs2_data = 32'h2000_0000 ^ pc;
      c.due = cyc; c.stall = exp_stall; c.a1 = inst[19:15]; c.a2 = inst[24:20];
      cq.push_back(c);
      if (hold) begin
         e = last_e;
         e.jce = 1'b0;
      end else if (e.v) begin
         e.pc = pc;
         e.r1 = 32'h1000_0000 ^ pc;
         e.r2 = 32'h2000_0000 ^ pc;
      end
      e.due = cyc + 1;
      eq.push_back(e);
      if (!hold) last_e = e;
   endtask

   localparam logic [31:0] ADDI  = 32'h00500093;
   localparam logic [31:0] LW    = 32'h0000A103;
   localparam logic [31:0] ADD   = 32'h001101B3;
   localparam logic [31:0] JAL   = 32'h020000EF;
   localparam logic [31:0] NOP   = 32'h00000013;

   initial begin
      ex_t e, e_addi, e_lw, e_jal;
      rst = 1'b1; in_valid = 0; in_pc = '0; in_inst = '0; stall_in = 0; flush_in = 0;
      rs1_data = '0; rs2_data = '0;
      last_e = bub(0);
      e_addi = mk(1, 1, 5, 1, 4'h0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      e_lw   = mk(1, 2, 0, 1, 4'h0, 0, 1, 1, 0, 3'd2, 0, 0, 0, 0, 0);
      repeat (2) @(negedge clk);
      check_zero("reset");
      rst = 1'b0;

      step(1, 32'h100, ADDI, 0, 0, 0, e_addi, 0);
      step(1, 32'h104, NOP, 1, 0, 1, bub(0), 1);
      step(1, 32'h104, LW, 0, 0, 0, e_lw, 0);
      step(1, 32'h108, ADD, 0, 0, 1, bub(0), 0);
      e = mk(1, 3, 0, 1, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); e.skip_imm = 1;
      step(1, 32'h108, ADD, 0, 0, 0, e, 0);
      step(1, 32'h10C, LW, 0, 0, 0, e_lw, 0);
      step(1, 32'h110, ADD, 1, 1, 0, bub(0), 0);
      step(1, 32'h114, 32'h4030D293, 0, 0, 0,
           mk(1, 5, 32'h403, 1, 4'hD, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0), 0);
      e = mk(1, 6, 0, 1, 4'h8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); e.skip_imm = 1;
      step(1, 32'h118, 32'h40208333, 0, 0, 0, e, 0);
      e = mk(1, 0, 8, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0); e.skip_rd = 1; e.skip_ctl = 1;
      step(1, 32'h11C, 32'h00208463, 0, 0, 0, e, 0);
      e = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      e.skip_rd = 1; e.skip_ctl = 1; e.skip_imm = 1;
      step(1, 32'h120, 32'hFFFFFFFF, 0, 0, 0, e, 0);
      step(1, 32'h124, 32'h00100013, 0, 0, 0,
           mk(1, 0, 1, 0, 4'h0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0), 0);
      step(1, 32'h128, 32'h800003B7, 0, 0, 0,
           mk(1, 7, 32'h80000000, 1, 4'h0, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0), 0);
      e = mk(1, 0, 32'hFFFFFFFC, 0, 4'h0, 0, 1, 0, 1, 3'd2, 0, 0, 0, 0, 0); e.skip_rd = 1;
      step(1, 32'h12C, 32'hFE20AE23, 0, 0, 0, e, 0);

      e_jal = mk(1, 1, 32'h20, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 32'h220); e_jal.skip_ctl = 1;
      step(1, 32'h200, JAL, 0, 0, 0, e_jal, 0);
      step(1, 32'h204, JAL, 0, 0, 0, bub(32'h220), 0);
      e = e_addi; e.ja = 32'h220;
      step(1, 32'h208, ADDI, 0, 0, 0, e, 0);

      e_jal.ja = 32'h320;
      step(1, 32'h300, JAL, 0, 0, 0, e_jal, 0);
      @(posedge clk);
      #1;
      in_valid = 1; in_pc = 32'h304; in_inst = NOP;
      @(negedge clk);
      #1;
      cmp("jump_ce_before_rst", jump_ce, 1);
      rst = 1'b1;
      #1;
      check_zero("async_rst");
      eq.delete();
      cq.delete();
      in_valid = 0;
      repeat (2) @(negedge clk);
      rst = 1'b0;

      step(1, 32'h100, ADDI, 0, 0, 0, e_addi, 0);
      step(0, 32'h104, ADDI, 0, 0, 0, bub(0), 0);

      repeat (3) @(negedge clk);
      #1;
      total++;
      if (eq.size() != 0 || cq.size() != 0) begin
         bad++;
         $display("FAIL drain got=%0d/%0d pending want=0/0", eq.size(), cq.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pid.md
# pid

Instruction decode stage of the five-stage RV32I pipeline. It sits directly downstream of the IF/ID register. It decodes the instruction and reads the register file through external read ports. It resolves JAL early as a one-cycle redirect pulse, detects load-use hazards against its own ID/EX register, and registers everything into the ID/EX register for the execute stage.

## Interface
- XLEN, 32, datapath and PC width
- RA_W, 5, register address width
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  IF/ID holds a valid instruction
- in_pc  in  XLEN  PC of in_inst
- in_inst  in  32  instruction word
- stall_in  in  1  execute stage cannot accept; ID/EX holds
- flush_in  in  1  execute-stage redirect; squash ID and ID/EX contents
- rs1_addr, rs2_addr  out  RA_W  combinational register-file read addresses
- rs1_data, rs2_data  in  XLEN  register-file read data; the register file is write-through
- stall_req  out  1  hold PC and IF/ID (combinational)
- jump_ce  out  1  registered one-cycle redirect pulse to IF
- jump_addr  out  XLEN  redirect target, valid while jump_ce=1
- ex_valid, ex_pc, ex_rs1_val, ex_rs2_val, ex_imm  out  1/XLEN/XLEN/XLEN/XLEN  ID/EX payload
- ex_rd  out  RA_W  destination register
- ex_wb_en  out  1  write-back enable, forced 0 when rd=0
- ex_alu_op  out  4  {funct7[5], funct3}
- ex_a_sel  out  2  operand A source: 0 rs1, 1 pc, 2 zero
- ex_b_imm  out  1  operand B is ex_imm
- ex_mem_rd, ex_mem_wr  out  1  load / store
- ex_mem_size  out  3  funct3 of the load or store
- ex_branch, ex_jump, ex_illegal  out  1  conditional branch / JAL or JALR (EX writes pc+4) / unsupported opcode

## Operation
- rs1_addr = in_inst[19:15] and rs2_addr = in_inst[24:20], always, regardless of in_valid.
- Decoded opcodes: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP.
  - Any other opcode sets ex_illegal=1, with wb_en, mem_rd, mem_wr, branch and jump all 0.
- Immediates are sign-extended to XLEN in I, S, B, U and J formats.
  - U-format: imm = inst[31:12]<<12.
- Per-opcode decode:
  - LUI: a_sel=2, b_imm=1, alu_op=ADD (0000).
  - AUIPC: a_sel=1, b_imm=1, alu_op=ADD.
  - OP-IMM: alu_op={inst[30] only when funct3=101, else 0, funct3}.
  - LOAD/STORE: alu_op=ADD, b_imm=1.
- Source usage:
  - rs1 is used by all decoded opcodes except LUI, AUIPC and JAL.
  - rs2 is used only by BRANCH, STORE and OP.
- Load-use hazard is asserted when all of the following hold:
  - in_valid=1;
  - ex_valid=1, ex_mem_rd=1 and ex_rd≠0;
  - a used source register equals ex_rd.
- stall_req = ~flush_in & (stall_in | hazard).
- ID/EX update priority, evaluated each rising edge:
  1. flush_in: ex_valid←0, jump_ce←0.
  2. stall_in: all ex_* hold.
  3. hazard: ex_valid←0 (bubble); other fields are don't-care.
  4. Otherwise, load the decoded payload with ex_valid←in_valid & ~drop.
- drop = jump_ce. The instruction in ID while jump_ce=1 is the wrong-path pc+4 instruction and is discarded.
- JAL handling:
  - Accepted when it loads into ID/EX with ex_valid=1 (not flushed, stalled, hazarded or dropped).
  - On acceptance: jump_ce←1 and jump_addr←in_pc+J-imm.
  - In every other cycle jump_ce←0. jump_addr holds its last value.
- JALR and branches are resolved in execute, not here.

## Timing
- Reset: all ex_* outputs 0 (ex_valid=0), jump_ce=0, jump_addr=0.
  - Reset is asynchronous and may assert mid-operation; outputs clear immediately.
  - After release, the first valid instruction appears on ex_* one cycle after acceptance.
- Latency: one cycle from in_* to ex_*. Throughput: one instruction per cycle.
- jump_ce is high for exactly one cycle: the cycle in which the JAL is on ex_*.
- A load-use stall lasts exactly one cycle unless stall_in extends it.
- flush_in together with stall_in or a hazard: the flush wins and stall_req=0.
- Back-to-back JALs: the second JAL is in ID while jump_ce=1, so it is dropped.

## Test plan
- addi x1,x0,5 (0x00500093) at pc 0x100 -> next cycle: ex_valid=1, ex_rd=1, ex_imm=5, ex_wb_en=1, ex_alu_op=0000, ex_a_sel=0, ex_b_imm=1.
- lw x2,0(x1) (0x0000A103), then add x3,x2,x1 (0x001101B3) -> stall_req=1 for one cycle, ex_valid=0 bubble, then ex_* carries the add with ex_rd=3.
- jal x1,+0x20 (0x020000EF) at pc 0x200 -> next cycle: jump_ce=1, jump_addr=0x220, ex_jump=1, ex_rd=1. The instruction in ID that cycle yields ex_valid=0.
- flush_in=1 and stall_in=1 in the same cycle with lw/add hazard present -> stall_req=0, ex_valid=0 next cycle.
- 0xFFFFFFFF with in_valid=1 -> ex_illegal=1, ex_wb_en=0, ex_mem_rd=0, ex_mem_wr=0; addi x0,x0,1 -> ex_wb_en=0.
- rst asserted mid-stream while jump_ce=1 -> jump_ce, jump_addr, ex_valid and all ex_* are 0 immediately.
